pipe_skid_reg: RTL and testbench

//   Parametrised multi-lane pipeline stage register with a valid/ready handshake and a 1-entry skid buffer.

---
 rtl/pipe_skid_reg.sv | 129 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: multi-lane pipeline stage register with valid/ready handshake
// and a one-entry skid buffer. Holds at most two groups (main + skid) so that
// in_rdy can come straight from a flop instead of following out_rdy.
// Optional feature: define PIPE_STALL_CNT_EN to add the saturating stall_cnt
// output and its CNT_W parameter.
module pipe_skid_reg #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 64
`ifdef PIPE_STALL_CNT_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [LANES-1:0]        in_vld,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    in_rdy,
    output logic [LANES-1:0]        out_vld,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    out_rdy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]        stall_cnt
`endif
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e                  state_q;
    logic [LANES-1:0]        main_vld_q;
    logic [LANES*DATA_W-1:0] main_data_q;
    logic [LANES-1:0]        skid_vld_q;
    logic [LANES*DATA_W-1:0] skid_data_q;
    logic [LANES*DATA_W-1:0] in_data_masked;
    logic                    push;
    logic                    pop;

    // Zero the payload of invalid lanes so stale operands never travel downstream.
    always_comb begin
        in_data_masked = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_vld[i]) begin
                in_data_masked[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // All-invalid groups are bubbles and are never stored.
    assign push     = in_rdy & (|in_vld) & ~flush;
    assign pop      = out_rdy & (state_q != StEmpty);
    assign in_rdy   = (state_q != StTwo);
    assign out_vld  = (state_q != StEmpty) ? main_vld_q : '0;
    assign out_data = main_data_q;

    // Occupancy FSM and main/skid storage; flush wins over every transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            main_vld_q  <= '0;
            main_data_q <= '0;
            skid_vld_q  <= '0;
            skid_data_q <= '0;
        end else if (flush) begin
            state_q    <= StEmpty;
            main_vld_q <= '0;
            skid_vld_q <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_q     <= StOne;
                        main_vld_q  <= in_vld;
                        main_data_q <= in_data_masked;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        main_vld_q  <= in_vld;
                        main_data_q <= in_data_masked;
                    end else if (push) begin
                        state_q     <= StTwo;
                        skid_vld_q  <= in_vld;
                        skid_data_q <= in_data_masked;
                    end else if (pop) begin
                        state_q <= StEmpty;
                    end
                end
                StTwo: begin
                    // in_rdy is low here, so only a pop can move the state.
                    if (pop) begin
                        state_q     <= StOne;
                        main_vld_q  <= skid_vld_q;
                        main_data_q <= skid_data_q;
                        skid_vld_q  <= '0;
                    end
                end
                default: begin
                    state_q    <= StEmpty;
                    main_vld_q <= '0;
                    skid_vld_q <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] stall_cnt_q;

    // Count cycles a group is held but not consumed; saturates, survives flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((state_q != StEmpty) && !out_rdy && !flush && (stall_cnt_q != CntMax)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized bench for pipe_skid_reg: a two-deep group queue is the reference.
module tb_pipe_skid_reg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned LW     = LANES * DATA_W;
    localparam int          NCYC   = 3000;

    typedef struct {
        logic [LANES-1:0] vld;
        logic [LW-1:0]    data;
    } group_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [LANES-1:0] in_vld;
    logic [LW-1:0]    in_data;
    logic             in_rdy;
    logic [LANES-1:0] out_vld;
    logic [LW-1:0]    out_data;
    logic             out_rdy;

    int checks   = 0;
    int failures = 0;

    group_t q[$];

`ifdef PIPE_STALL_CNT_EN
    logic [3:0] stall_cnt;
    int         cnt_exp = 0;

    pipe_skid_reg #(.LANES(LANES), .DATA_W(DATA_W), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_data(in_data),
        .in_rdy(in_rdy), .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy),
        .stall_cnt(stall_cnt)
    );
`else
    pipe_skid_reg #(.LANES(LANES), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_data(in_data),
        .in_rdy(in_rdy), .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy)
    );
`endif

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare all outputs against the queue model.
    task automatic check_outputs();
        check_eq("in_rdy", LW'(in_rdy), LW'(q.size() < 2));
        if (q.size() > 0) begin
            check_eq("out_vld", LW'(out_vld), LW'(q[0].vld));
            check_eq("out_data", out_data, q[0].data);
        end else begin
            check_eq("out_vld_empty", LW'(out_vld), '0);
        end
`ifdef PIPE_STALL_CNT_EN
        check_eq("stall_cnt", LW'(stall_cnt), LW'(cnt_exp));
`endif
    endtask

    function automatic logic [LW-1:0] mask_group(input logic [LANES-1:0] v, input logic [LW-1:0] d);
        logic [LW-1:0] r = '0;
        for (int i = 0; i < LANES; i++) begin
            if (v[i]) r[i*DATA_W +: DATA_W] = d[i*DATA_W +: DATA_W];
        end
        return r;
    endfunction

    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        in_vld  = '0;
        in_data = '0;
        out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("reset_out_data", out_data, '0);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            bit     push;
            bit     pop;
            group_t g;

            check_outputs();

            if (cyc == NCYC / 2) begin
                // Asynchronous reset mid-stream: held groups vanish without a clock edge.
                rst     = 1'b1;
                flush   = 1'b0;
                in_vld  = '0;
                out_rdy = 1'b0;
                #1;
                check_eq("async_rst_vld", LW'(out_vld), '0);
                check_eq("async_rst_rdy", LW'(in_rdy), LW'(1));
                check_eq("async_rst_data", out_data, '0);
                q.delete();
`ifdef PIPE_STALL_CNT_EN
                cnt_exp = 0;
`endif
                @(negedge clk);
                rst = 1'b0;
                continue;
            end

            // Random stimulus: occasional bubbles, flushes and downstream stalls.
            in_vld = ($urandom_range(7) == 0) ? '0 : LANES'($urandom);
            for (int i = 0; i < LANES; i++) begin
                in_data[i*DATA_W +: DATA_W] = {$urandom, $urandom};
            end
            out_rdy = ($urandom_range(9) < 6);
            flush   = ($urandom_range(15) == 0);

            push = (q.size() < 2) && (in_vld != '0) && !flush;
            pop  = out_rdy && (q.size() > 0);
`ifdef PIPE_STALL_CNT_EN
            if ((q.size() > 0) && !out_rdy && !flush && (cnt_exp < 15)) cnt_exp++;
`endif
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) begin
                    g.vld  = in_vld;
                    g.data = mask_group(in_vld, in_data);
                    q.push_back(g);
                end
            end

            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
